vend_ctrl_multi: RTL and testbench
==================================

Name: vend_ctrl_multi

Overview:
Parametrised successor to the two-beverage vending FSM. Supports NUM_BEV beverages with per-slot prices and per-slot stock tracking, a cancel/refund path and a capped credit register. Delivery delays are synthesizable cycle counters instead of simulation delays. Sits between the coin/button front end and the dispenser/change actuators; the existing verification interface wraps its ports.

Parameters:
CW, 16, credit/coin/change width in bits
NUM_BEV, 4, number of beverage slots (2..8)
PRICES, {16'd120,16'd80,16'd50,16'd30}, packed NUM_BEV*CW price vector; slot i = PRICES[i*CW +: CW] (slot0=30, slot1=50, slot2=80, slot3=120)
STOCK_INIT, 8, units per slot after reset/restock (max 255)
MAX_CREDIT, 500, credit ceiling
BEV_DLY, 1, cycles in WAIT_BEV before dispense (>=1)
CHG_DLY, 2, cycles in WAIT_CHG before change delivery (>=1)
SW, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0)
coin_in  in  CW  coin value, sampled when coin_valid=1
coin_valid  in  1  coin strobe
sel_in  in  $clog2(NUM_BEV)  beverage index
sel_valid  in  1  selection strobe
cancel  in  1  refund request
restock  in  1  reload all slots to STOCK_INIT
bev_valid  out  1  one-cycle dispense pulse
bev_id  out  $clog2(NUM_BEV)  dispensed slot, valid with bev_valid
change_valid  out  1  one-cycle change pulse
change_out  out  CW  change amount, valid with change_valid, else 0
coin_reject  out  1  one-cycle pulse: coin returned unaccepted
sel_reject  out  1  one-cycle pulse: selection refused
credit  out  CW  current credit
busy  out  1  high in every state except IDLE
sold_out  out  NUM_BEV  bit i high when stock[i]==0
cnt_vend  out  SW  total beverages dispensed
cnt_change  out  SW  change deliveries (incl. refunds)
cnt_no_money  out  SW  IDLE cycles with credit < MIN_PRICE

Behaviour:
- Reset (rst=0, async): state=IDLE, credit=0, all pulses 0, change_out=0, bev_id=0, stock[i]=STOCK_INIT, all counters 0.
- MIN_PRICE = minimum of PRICES, computed at elaboration.
- Admissible coins: 10,20,50,100,200. All pulses last exactly one cycle, registered.
- States: IDLE, WAIT_BEV, DISPENSE, CHG_CHK, WAIT_CHG, CHANGE.
- IDLE, one event per cycle, priority cancel > sel_valid > coin_valid > restock:
  - cancel with credit>0 -> WAIT_CHG (full refund). cancel with credit==0 is ignored.
  - sel_valid with sel_in<NUM_BEV, credit>=price[sel_in] and stock[sel_in]>0: latch sel, go to WAIT_BEV. Otherwise sel_reject=1 and stay.
  - coin_valid: admissible and credit+coin<=MAX_CREDIT -> credit+=coin. Otherwise coin_reject=1, credit unchanged.
  - Lower-priority strobes in the same cycle are dropped; a dropped coin asserts coin_reject.
  - restock alone: stock[*]=STOCK_INIT.
  - cnt_no_money increments each IDLE cycle with credit<MIN_PRICE.
- WAIT_BEV: stays exactly BEV_DLY cycles, then DISPENSE.
- DISPENSE (1 cycle): credit-=price[sel], stock[sel]-=1, bev_valid=1, bev_id=sel, cnt_vend+=1; then CHG_CHK.
- CHG_CHK (1 cycle): if 0<credit<MIN_PRICE -> WAIT_CHG; else -> IDLE with credit retained.
- WAIT_CHG: stays exactly CHG_DLY cycles, then CHANGE.
- CHANGE (1 cycle): change_valid=1, change_out=credit, credit=0, cnt_change+=1; then IDLE.
- Outside IDLE, all strobes are ignored, except coin_valid, which asserts coin_reject.
- Counters saturate at all-ones. Stock never underflows.
- Latencies: accepted sel in IDLE at cycle t -> bev_valid at t+BEV_DLY+1. Change pulse follows CHG_CHK after CHG_DLY+1 cycles.
- Reset asserted mid-vend: everything returns to reset values immediately; no pulse is emitted and credit is lost.

Test Plan:
- Insert 20,10, select slot0 (30) -> bev_valid, bev_id=0 two cycles after sel; credit 0; no change_valid; cnt_vend=1.
- Insert 50,20, select slot1 (50) -> bev_valid; credit 20<30, so change_valid with change_out=20 three cycles after CHG_CHK; cnt_change=1.
- Insert 100, select slot0 -> credit 70 retained, no change. Then cancel -> change_out=70, credit 0.
- Insert coin 30 -> coin_reject, credit 0. Insert 200,200,200 -> third coin rejected, credit 400. Select slot3 with credit 100 -> sel_reject.
- Vend slot0 eight times -> sold_out[0]=1, ninth sel_reject. Then restock -> sold_out[0]=0.
- Drive rst=0 during WAIT_CHG with credit 20 -> credit=0, no change_valid, state IDLE. Also drive cancel+sel_valid+coin_valid in the same cycle -> only cancel acts, coin_reject=1.

Source files
------------

// File: rtl/vend_if.sv
// Port bundle between the coin/button front end and the vending controller.
// The front end drives the strobes; the controller drives pulses, status and counters.
interface vend_if #(
  parameter int CW      = 16,
  parameter int NUM_BEV = 4,
  parameter int SW      = 16
);
  localparam int SELW = (NUM_BEV > 1) ? $clog2(NUM_BEV) : 1;

  logic [CW-1:0]      coin_in;
  logic               coin_valid;
  logic [SELW-1:0]    sel_in;
  logic               sel_valid;
  logic               cancel;
  logic               restock;
  logic               bev_valid;
  logic [SELW-1:0]    bev_id;
  logic               change_valid;
  logic [CW-1:0]      change_out;
  logic               coin_reject;
  logic               sel_reject;
  logic [CW-1:0]      credit;
  logic               busy;
  logic [NUM_BEV-1:0] sold_out;
  logic [SW-1:0]      cnt_vend;
  logic [SW-1:0]      cnt_change;
  logic [SW-1:0]      cnt_no_money;

  modport master (
    output coin_in, coin_valid, sel_in, sel_valid, cancel, restock,
    input  bev_valid, bev_id, change_valid, change_out, coin_reject, sel_reject,
           credit, busy, sold_out, cnt_vend, cnt_change, cnt_no_money
  );

  modport slave (
    input  coin_in, coin_valid, sel_in, sel_valid, cancel, restock,
    output bev_valid, bev_id, change_valid, change_out, coin_reject, sel_reject,
           credit, busy, sold_out, cnt_vend, cnt_change, cnt_no_money
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-slot vending controller: credit accumulation, per-slot price/stock,
// counted dispense/change delays, cancel refund and saturating statistics.
module vend_ctrl_multi #(
  parameter int                      CW         = 16,
  parameter int                      NUM_BEV    = 4,
  parameter logic [NUM_BEV*CW-1:0]   PRICES     = {16'd120, 16'd80, 16'd50, 16'd30},
  parameter int                      STOCK_INIT = 8,
  parameter int                      MAX_CREDIT = 500,
  parameter int                      BEV_DLY    = 1,
  parameter int                      CHG_DLY    = 2,
  parameter int                      SW         = 16
) (
  input  logic  clk,
  input  logic  rst,
  vend_if.slave bus
);
  localparam int SELW = (NUM_BEV > 1) ? $clog2(NUM_BEV) : 1;
  localparam int DMAX = (BEV_DLY > CHG_DLY) ? BEV_DLY : CHG_DLY;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX + 1) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_BEV = 3'd1;
  localparam logic [2:0] DISPENSE = 3'd2;
  localparam logic [2:0] CHG_CHK  = 3'd3;
  localparam logic [2:0] WAIT_CHG = 3'd4;
  localparam logic [2:0] CHANGE   = 3'd5;

  function automatic logic [CW-1:0] min_price();
    logic [CW-1:0] m;
    m = PRICES[CW-1:0];
    for (int i = 1; i < NUM_BEV; i++)
      if (PRICES[i*CW +: CW] < m) m = PRICES[i*CW +: CW];
    return m;
  endfunction

  localparam logic [CW-1:0] MIN_PRICE = min_price();

  function automatic logic coin_adm(input logic [CW-1:0] c);
    return (c == CW'(10)) || (c == CW'(20)) || (c == CW'(50)) ||
           (c == CW'(100)) || (c == CW'(200));
  endfunction

  logic [2:0]                 state;
  logic [DW-1:0]              dly_cnt;
  logic [SELW-1:0]            sel;
  logic [CW-1:0]              credit;
  logic                       bev_valid, change_valid, coin_reject, sel_reject;
  logic [SELW-1:0]            bev_id;
  logic [CW-1:0]              change_out;
  logic [SW-1:0]              cnt_vend, cnt_change, cnt_no_money;
  logic [NUM_BEV-1:0][7:0]    stock;
  logic [NUM_BEV-1:0]         sold;

  // Slot lookups by matching rather than indexing, so an out-of-range
  // sel_in simply finds no slot (zero stock) and is refused.
  logic [CW-1:0] price_req, price_sel;
  logic [7:0]    stock_req;
  always_comb begin
    price_req = '0;
    stock_req = '0;
    price_sel = '0;
    for (int i = 0; i < NUM_BEV; i++) begin
      if (bus.sel_in == SELW'(i)) begin
        price_req = PRICES[i*CW +: CW];
        stock_req = stock[i];
      end
      if (sel == SELW'(i)) price_sel = PRICES[i*CW +: CW];
    end
  end

  logic        idle, take_cancel, take_sel, take_coin, coin_acc, do_restock, do_vend, sel_ok;
  logic [CW:0] coin_sum;

  assign idle        = (state == IDLE);
  assign take_cancel = idle & bus.cancel;
  assign take_sel    = idle & ~bus.cancel & bus.sel_valid;
  assign take_coin   = idle & ~bus.cancel & ~bus.sel_valid & bus.coin_valid;
  assign do_restock  = idle & ~bus.cancel & ~bus.sel_valid & ~bus.coin_valid & bus.restock;
  assign do_vend     = (state == DISPENSE);
  assign coin_sum    = {1'b0, credit} + {1'b0, bus.coin_in};
  assign coin_acc    = take_coin & coin_adm(bus.coin_in) & (coin_sum <= (CW+1)'(MAX_CREDIT));
  assign sel_ok      = (credit >= price_req) && (stock_req != 8'd0);

  for (genvar i = 0; i < NUM_BEV; i++) begin : g_slot
    logic [7:0] q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                             q <= 8'(STOCK_INIT);
      else if (do_restock)                                  q <= 8'(STOCK_INIT);
      else if (do_vend && sel == SELW'(i) && q != 8'd0)     q <= q - 8'd1;
    end
    assign stock[i] = q;
    assign sold[i]  = (q == 8'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dly_cnt      <= '0;
      sel          <= '0;
      credit       <= '0;
      bev_valid    <= 1'b0;
      bev_id       <= '0;
      change_valid <= 1'b0;
      change_out   <= '0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      cnt_vend     <= '0;
      cnt_change   <= '0;
      cnt_no_money <= '0;
    end else begin
      bev_valid    <= 1'b0;
      change_valid <= 1'b0;
      change_out   <= '0;
      sel_reject   <= 1'b0;
      // Any coin not credited this cycle goes back to the customer.
      coin_reject  <= bus.coin_valid & ~coin_acc;
      if (idle && credit < MIN_PRICE && cnt_no_money != '1)
        cnt_no_money <= cnt_no_money + 1'b1;

      case (state)
        IDLE: begin
          if (take_cancel) begin
            if (credit != '0) begin
              state   <= WAIT_CHG;
              dly_cnt <= '0;
            end
          end else if (take_sel) begin
            if (sel_ok) begin
              sel     <= bus.sel_in;
              state   <= WAIT_BEV;
              dly_cnt <= '0;
            end else begin
              sel_reject <= 1'b1;
            end
          end else if (coin_acc) begin
            credit <= credit + bus.coin_in;
          end
        end
        WAIT_BEV: begin
          if (dly_cnt == DW'(BEV_DLY - 1)) state <= DISPENSE;
          else                             dly_cnt <= dly_cnt + 1'b1;
        end
        DISPENSE: begin
          credit    <= credit - price_sel;
          bev_valid <= 1'b1;
          bev_id    <= sel;
          if (cnt_vend != '1) cnt_vend <= cnt_vend + 1'b1;
          state     <= CHG_CHK;
        end
        CHG_CHK: begin
          // Leftover too small to buy anything is returned; otherwise kept.
          if (credit != '0 && credit < MIN_PRICE) begin
            state   <= WAIT_CHG;
            dly_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_CHG: begin
          if (dly_cnt == DW'(CHG_DLY - 1)) state <= CHANGE;
          else                             dly_cnt <= dly_cnt + 1'b1;
        end
        CHANGE: begin
          change_valid <= 1'b1;
          change_out   <= credit;
          credit       <= '0;
          if (cnt_change != '1) cnt_change <= cnt_change + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bev_valid    = bev_valid;
  assign bus.bev_id       = bev_id;
  assign bus.change_valid = change_valid;
  assign bus.change_out   = change_out;
  assign bus.coin_reject  = coin_reject;
  assign bus.sel_reject   = sel_reject;
  assign bus.credit       = credit;
  assign bus.busy         = ~idle;
  assign bus.sold_out     = sold;
  assign bus.cnt_vend     = cnt_vend;
  assign bus.cnt_change   = cnt_change;
  assign bus.cnt_no_money = cnt_no_money;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: cycle-by-cycle vector table plus
// hand sequences for sell-out/restock, async reset mid-vend and counters.
module tb_vend_ctrl_multi;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_if #(.CW(16), .NUM_BEV(4), .SW(16)) bus ();

  vend_ctrl_multi dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit cv; int coin; bit sv; int sel; bit can; bit rs;
    int cr; bit crj; bit srj; bit bv; int bid; bit chv; int chg; bit bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit cv, int coin, bit sv, int sel, bit can, bit rs,
                              int cr, bit crj, bit srj, bit bv, int bid, bit chv, int chg, bit bsy);
    vec_t v;
    v.cv = cv; v.coin = coin; v.sv = sv; v.sel = sel; v.can = can; v.rs = rs;
    v.cr = cr; v.crj = crj; v.srj = srj; v.bv = bv; v.bid = bid; v.chv = chv; v.chg = chg; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit cv, input int coin, input bit sv, input int sel,
                       input bit can, input bit rs);
    bus.coin_valid = cv;  bus.coin_in = 16'(coin);
    bus.sel_valid  = sv;  bus.sel_in  = 2'(sel);
    bus.cancel     = can; bus.restock = rs;
    @(posedge clk); #1;
    bus.coin_valid = 1'b0; bus.sel_valid = 1'b0; bus.cancel = 1'b0; bus.restock = 1'b0;
    bus.coin_in = '0; bus.sel_in = '0;
  endtask

  task automatic idle_cyc(); cycle(0, 0, 0, 0, 0, 0); endtask
  task automatic coin(input int c); cycle(1, c, 0, 0, 0, 0); endtask
  task automatic pick(input int s); cycle(0, 0, 1, s, 0, 0); endtask

  initial begin
    bit saw_chg;
    bit got_bev;
    // inputs                      | credit crj srj bv bid chv chg busy
    vecs.push_back(mk(1, 20,0,0,0,0,  20,0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 10,0,0,0,0,  30,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,  0,1,0,0,0,  30,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  30,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,   0,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,   0,0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 50,0,0,0,0,  50,0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 20,0,0,0,0,  70,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,  0,1,1,0,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  20,0,0,1,1,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  20,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  20,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  20,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,   0,0,0,0,0,1,20,0));
    vecs.push_back(mk(1,100,0,0,0,0, 100,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,  0,1,0,0,0, 100,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0, 100,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,  0,0,0,1,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,   0,0,0,0,0,1,70,0));
    vecs.push_back(mk(1, 30,0,0,0,0,   0,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,200,0,0,0,0, 200,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,200,0,0,0,0, 400,0,0,0,0,0,0,0));
    vecs.push_back(mk(1,200,0,0,0,0, 400,1,0,0,0,0,0,0));
    vecs.push_back(mk(1,100,0,0,0,0, 500,0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 10,0,0,0,0, 500,1,0,0,0,0,0,0));
    vecs.push_back(mk(0,  0,0,0,1,0, 500,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0, 500,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0, 500,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,   0,0,0,0,0,1,500,0));
    vecs.push_back(mk(1,100,0,0,0,0, 100,0,0,0,0,0,0,0));
    vecs.push_back(mk(0,  0,1,3,0,0, 100,0,1,0,0,0,0,0));
    vecs.push_back(mk(1, 10,1,3,0,0, 100,1,1,0,0,0,0,0));
    vecs.push_back(mk(0,  0,1,0,0,0, 100,0,0,0,0,0,0,1));
    vecs.push_back(mk(1, 10,0,0,0,0, 100,1,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,1,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,0));
    vecs.push_back(mk(1, 10,1,0,1,0,  70,1,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,  70,0,0,0,0,0,0,1));
    vecs.push_back(mk(0,  0,0,0,0,0,   0,0,0,0,0,1,70,0));
    vecs.push_back(mk(0,  0,0,0,1,0,   0,0,0,0,0,0,0,0));

    bus.coin_valid = 0; bus.coin_in = '0; bus.sel_valid = 0; bus.sel_in = '0;
    bus.cancel = 0; bus.restock = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit",    bus.credit, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_bev_valid", bus.bev_valid, 0);
    chk("rst_bev_id",    bus.bev_id, 0);
    chk("rst_chg_valid", bus.change_valid, 0);
    chk("rst_chg_out",   bus.change_out, 0);
    chk("rst_sold_out",  bus.sold_out, 0);
    chk("rst_cnt_vend",  bus.cnt_vend, 0);
    chk("rst_cnt_chg",   bus.cnt_change, 0);
    chk("rst_cnt_nomny", bus.cnt_no_money, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].cv, vecs[i].coin, vecs[i].sv, vecs[i].sel, vecs[i].can, vecs[i].rs);
      chk($sformatf("v%0d_credit", i),   bus.credit, vecs[i].cr);
      chk($sformatf("v%0d_coin_rej", i), bus.coin_reject, vecs[i].crj);
      chk($sformatf("v%0d_sel_rej", i),  bus.sel_reject, vecs[i].srj);
      chk($sformatf("v%0d_bev_vld", i),  bus.bev_valid, vecs[i].bv);
      if (vecs[i].bv) chk($sformatf("v%0d_bev_id", i), bus.bev_id, vecs[i].bid);
      chk($sformatf("v%0d_chg_vld", i),  bus.change_valid, vecs[i].chv);
      chk($sformatf("v%0d_chg_out", i),  bus.change_out, vecs[i].chg);
      chk($sformatf("v%0d_busy", i),     bus.busy, vecs[i].bsy);
    end
    chk("tbl_cnt_vend",   bus.cnt_vend, 4);
    chk("tbl_cnt_change", bus.cnt_change, 4);
    chk("tbl_sold_out",   bus.sold_out, 0);

    // Sell out slot0 from a fresh reset, then restock
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      coin(20); coin(10); pick(0);
      got_bev = 0;
      for (int w = 0; w < 10 && !got_bev; w++) begin
        idle_cyc();
        if (bus.bev_valid) got_bev = 1;
      end
      chk($sformatf("so%0d_bev_seen", k), got_bev, 1);
      idle_cyc();
    end
    chk("so_sold_out",  bus.sold_out, 4'b0001);
    chk("so_cnt_vend",  bus.cnt_vend, 8);
    coin(20); coin(10); pick(0);
    chk("so_ninth_rej", bus.sel_reject, 1);
    chk("so_ninth_busy", bus.busy, 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("restock_sold_out", bus.sold_out, 0);
    chk("restock_credit",   bus.credit, 30);

    // Async reset while waiting to return 20 change
    coin(20); coin(20); pick(1);
    idle_cyc(); idle_cyc(); idle_cyc();
    chk("mid_busy",   bus.busy, 1);
    chk("mid_credit", bus.credit, 20);
    chk("mid_stock1", bus.sold_out, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("arst_credit",   bus.credit, 0);
    chk("arst_busy",     bus.busy, 0);
    chk("arst_cnt_vend", bus.cnt_vend, 0);
    chk("arst_chg_vld",  bus.change_valid, 0);
    @(posedge clk); @(negedge clk); rst = 1'b1;
    saw_chg = 0;
    for (int k = 0; k < 6; k++) begin
      idle_cyc();
      if (bus.change_valid) saw_chg = 1;
    end
    chk("arst_no_change", saw_chg, 0);
    chk("nomoney_6",      bus.cnt_no_money, 6);
    coin(50);
    chk("nomoney_coin_rej", bus.coin_reject, 0);
    idle_cyc();
    chk("nomoney_7",      bus.cnt_no_money, 7);
    chk("nomoney_credit", bus.credit, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
